fft_out_reorder: RTL and testbench

Parametrised output stage for the in-place FFT. It accepts the core's dual-lane result stream, two complex samples per cycle, and buffers each frame in a ping-pong memory. It replays the frame one sample per cycle in natural frequency order, with valid/ready flow control, frame markers and resync error reporting. It sits between the FFT core's outReal0/outImag0/outReal1/outImag1 lanes and downstream consumers.

---
 rtl/fft_out_reorder.sv | 150 +++++++++++++++
 tb/tb_fft_out_reorder.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_out_reorder.sv
// Ping-pong output reorder buffer for the in-place FFT: dual-lane frame writes, single-lane replay.
// Define FFT_REORDER_BITREV_EN to read in bit-reversed address order (natural frequency order out).
module fft_out_reorder #(
    parameter int N = 64,
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         in_start,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_re0,
    input  logic [W-1:0] in_im0,
    input  logic [W-1:0] in_re1,
    input  logic [W-1:0] in_im1,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_re,
    output logic [W-1:0] out_im,
    output logic         out_first,
    output logic         out_last,
    output logic         sync_err
);

    localparam int AW = $clog2(N);
    localparam int PW = AW - 1;
    localparam logic [PW-1:0] WC_LAST = PW'(N/2 - 1);
    localparam logic [AW-1:0] RC_LAST = AW'(N - 1);

    // Bank select is the top address bit: bank b occupies entries b*N .. b*N+N-1.
    logic [W-1:0] mem_re [0:2*N-1];
    logic [W-1:0] mem_im [0:2*N-1];

    logic [1:0]    full_reg;
    logic [1:0]    full_next;
    logic          wb_reg;
    logic          rb_reg;
    logic          armed_reg;
    logic [PW-1:0] wc_reg;
    logic [AW-1:0] rc_reg;

    logic          accept;
    logic          do_write;
    logic [PW-1:0] wr_pair;
    logic [AW:0]   wr_addr0;
    logic [AW:0]   wr_addr1;
    logic          frame_done;
    logic          load;
    logic          frame_out;
    logic [AW-1:0] rd_ofs;
    logic [AW:0]   rd_addr;

    assign in_ready   = !full_reg[wb_reg];
    assign accept     = in_valid && in_ready;
    assign do_write   = accept && (in_start || armed_reg);
    // A start always restarts the frame at pair 0, whatever the counter holds.
    assign wr_pair    = in_start ? '0 : wc_reg;
    assign wr_addr0   = {wb_reg, wr_pair, 1'b0};
    assign wr_addr1   = {wb_reg, wr_pair, 1'b1};
    assign frame_done = do_write && (wr_pair == WC_LAST);

    assign load       = full_reg[rb_reg] && (!out_valid || out_ready);
    assign frame_out  = load && (rc_reg == RC_LAST);
    assign rd_addr    = {rb_reg, rd_ofs};

`ifdef FFT_REORDER_BITREV_EN
    for (genvar gi = 0; gi < AW; gi++) begin : g_bitrev
        assign rd_ofs[gi] = rc_reg[AW-1-gi];
    end
`else
    assign rd_ofs = rc_reg;
`endif

    // Write and read never share a bank, so a bank can be filled and the other freed together.
    always_comb begin
        full_next = full_reg;
        if (frame_done) begin
            full_next[wb_reg] = 1'b1;
        end
        if (frame_out) begin
            full_next[rb_reg] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_re[wr_addr0] <= in_re0;
            mem_im[wr_addr0] <= in_im0;
            mem_re[wr_addr1] <= in_re1;
            mem_im[wr_addr1] <= in_im1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            full_reg  <= 2'b00;
            wb_reg    <= 1'b0;
            armed_reg <= 1'b0;
            wc_reg    <= '0;
            sync_err  <= 1'b0;
        end else begin
            full_reg <= full_next;
            sync_err <= 1'b0;
            if (accept) begin
                if (in_start) begin
                    sync_err  <= (wc_reg != '0);
                    armed_reg <= 1'b1;
                    wc_reg    <= PW'(1);
                end else if (armed_reg) begin
                    if (wc_reg == WC_LAST) begin
                        wc_reg    <= '0;
                        armed_reg <= 1'b0;
                        wb_reg    <= ~wb_reg;
                    end else begin
                        wc_reg <= wc_reg + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rb_reg    <= 1'b0;
            rc_reg    <= '0;
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (load) begin
                out_re    <= mem_re[rd_addr];
                out_im    <= mem_im[rd_addr];
                out_first <= (rc_reg == '0);
                out_last  <= (rc_reg == RC_LAST);
                out_valid <= 1'b1;
                if (frame_out) begin
                    rc_reg <= '0;
                    rb_reg <= ~rb_reg;
                end else begin
                    rc_reg <= rc_reg + 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fft_out_reorder.sv
// Self-checking bench for fft_out_reorder: directed table, sync/back-pressure/reset sequences,
// and randomized traffic against a queue-based frame model.
module tb_fft_out_reorder;

    localparam int N     = 8;
    localparam int W     = 16;
    localparam int LOG2N = 3;

    logic         clk = 1'b0;
    logic         nrst;
    logic         in_start;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_re0;
    logic [W-1:0] in_im0;
    logic [W-1:0] in_re1;
    logic [W-1:0] in_im1;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_re;
    logic [W-1:0] out_im;
    logic         out_first;
    logic         out_last;
    logic         sync_err;

    fft_out_reorder #(.N(N), .W(W)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .in_start  (in_start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re0    (in_re0),
        .in_im0    (in_im0),
        .in_re1    (in_re1),
        .in_im1    (in_im1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_first (out_first),
        .out_last  (out_last),
        .sync_err  (sync_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] re;
        logic [W-1:0] im;
        logic         first;
        logic         last;
    } samp_t;

    typedef struct packed {
        logic         start;
        logic [W-1:0] re0;
        logic [W-1:0] im0;
        logic [W-1:0] re1;
        logic [W-1:0] im1;
    } pair_t;

    typedef struct {
        logic [W-1:0] in_re;
        logic [W-1:0] exp_re;
        logic         exp_first;
        logic         exp_last;
    } vec_t;

    samp_t exp_q[$];
    samp_t part_q[$];
    samp_t out_log[$];
    pair_t send_q[$];
    samp_t held;
    bit    held_valid;
    bit    armed_m;
    bit    sync_exp;
    bit    prev_ov;
    bit    rnd_ready;
    int    n_checks;
    int    n_fail;
    int    cyc;
    int    consumed;
    int    sync_seen;
    int    done_cyc;
    int    rise_cyc;

    function automatic int brev(input int v);
        int r = 0;
        for (int i = 0; i < LOG2N; i++) begin
            r = r | (((v >> i) & 1) << (LOG2N - 1 - i));
        end
        return r;
    endfunction

    // Buffer position that supplies output sample k.
    function automatic int src_of(input int k);
`ifdef FFT_REORDER_BITREV_EN
        return brev(k);
`else
        return k;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        samp_t cur;
        samp_t e;
        samp_t s;
        cyc++;
        if (!nrst) begin
            exp_q.delete();
            part_q.delete();
            armed_m    = 1'b0;
            sync_exp   = 1'b0;
            held_valid = 1'b0;
            prev_ov    = 1'b0;
            return;
        end
        check("sync_err", 64'(sync_err), 64'(sync_exp));
        sync_exp = 1'b0;
        if (sync_err) sync_seen++;
        cur = {out_re, out_im, out_first, out_last};
        if (out_valid) begin
            if (!prev_ov) rise_cyc = cyc;
            if (held_valid) check("hold_stable", 64'(cur), 64'(held));
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_sample: got %0h, expected no sample (cycle %0d)", cur, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("sample", 64'(cur), 64'(e));
                end
                out_log.push_back(cur);
                consumed++;
                held_valid = 1'b0;
            end else begin
                held_valid = 1'b1;
                held       = cur;
            end
        end else if (held_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL valid_dropped: got out_valid=0, expected 1 while stalled (cycle %0d)", cyc);
            held_valid = 1'b0;
        end
        prev_ov = out_valid;
        if (in_valid && in_ready) begin
            if (send_q.size() > 0) void'(send_q.pop_front());
            if (in_start) begin
                if (part_q.size() != 0) sync_exp = 1'b1;
                part_q.delete();
                armed_m = 1'b1;
            end
            if (armed_m) begin
                part_q.push_back({in_re0, in_im0, 1'b0, 1'b0});
                part_q.push_back({in_re1, in_im1, 1'b0, 1'b0});
                if (part_q.size() == N) begin
                    for (int k = 0; k < N; k++) begin
                        s       = part_q[src_of(k)];
                        s.first = (k == 0);
                        s.last  = (k == N - 1);
                        exp_q.push_back(s);
                    end
                    part_q.delete();
                    armed_m  = 1'b0;
                    done_cyc = cyc;
                end
            end
        end
    endtask

    task automatic drive();
        if (send_q.size() > 0) begin
            in_valid = 1'b1;
            in_start = send_q[0].start;
            in_re0   = send_q[0].re0;
            in_im0   = send_q[0].im0;
            in_re1   = send_q[0].re1;
            in_im1   = send_q[0].im1;
        end else begin
            in_valid = 1'b0;
            in_start = 1'b0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
        drive();
    endtask

    task automatic push_pair(input logic st, input logic [W-1:0] r0, input logic [W-1:0] r1);
        send_q.push_back({st, r0, W'(r0 + 100), r1, W'(r1 + 100)});
    endtask

    task automatic push_rand_frame();
        for (int k = 0; k < N/2; k++) begin
            send_q.push_back({(k == 0), W'($urandom), W'($urandom), W'($urandom), W'($urandom)});
        end
    endtask

    task automatic run_until_idle(input string name, input int budget);
        int b = budget;
        while ((send_q.size() != 0 || exp_q.size() != 0 || out_valid) && b > 0) begin
            tick();
            b--;
        end
        check({name, "_drained"}, 64'(b == 0), 64'(0));
    endtask

    vec_t tbl [N];
    int   exp_seq [N];
    int   c0;
    int   b;
    int   log0;

    initial begin
        nrst      = 1'b0;
        in_start  = 1'b0;
        in_valid  = 1'b0;
        in_re0    = '0;
        in_im0    = '0;
        in_re1    = '0;
        in_im1    = '0;
        out_ready = 1'b0;
        rnd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'({out_re, out_im, out_first, out_last}), 64'(0));
        check("rst_sync_err", 64'(sync_err), 64'(0));
        nrst = 1'b1;
        tick();

        // Directed frame, expected order written out by hand.
`ifdef FFT_REORDER_BITREV_EN
        exp_seq = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
        exp_seq = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
        for (int i = 0; i < N; i++) begin
            tbl[i].in_re     = W'(i);
            tbl[i].exp_re    = W'(exp_seq[i]);
            tbl[i].exp_first = (i == 0);
            tbl[i].exp_last  = (i == N - 1);
        end
        out_ready = 1'b1;
        out_log.delete();
        for (int k = 0; k < N/2; k++) push_pair((k == 0), tbl[2*k].in_re, tbl[2*k+1].in_re);
        drive();
        run_until_idle("table", 100);
        check("table_count", 64'(out_log.size()), 64'(N));
        for (int i = 0; i < N; i++) begin
            if (i < out_log.size()) begin
                check($sformatf("table_vec%0d", i), 64'(out_log[i]),
                      64'({tbl[i].exp_re, W'(tbl[i].exp_re + 100), tbl[i].exp_first, tbl[i].exp_last}));
            end
        end
        check("latency", 64'(rise_cyc - done_cyc), 64'(2));

        // Unarmed pairs dropped, then a restart after two pairs of a partial frame.
        out_log.delete();
        sync_seen = 0;
        push_pair(1'b0, 16'h0a0, 16'h0a1);
        push_pair(1'b0, 16'h0a2, 16'h0a3);
        push_pair(1'b1, 16'h0b0, 16'h0b1);
        push_pair(1'b0, 16'h0b2, 16'h0b3);
        for (int k = 0; k < N/2; k++) push_pair((k == 0), W'(16'h0c0 + 2*k), W'(16'h0c1 + 2*k));
        drive();
        run_until_idle("sync", 100);
        check("sync_pulses", 64'(sync_seen), 64'(1));
        check("sync_count", 64'(out_log.size()), 64'(N));
        if (out_log.size() > 0) check("sync_first", 64'(out_log[0].re), 64'(16'h0c0));

        // Three frames with the output stalled: third frame must wait for a free bank.
        out_ready = 1'b0;
        push_rand_frame();
        push_rand_frame();
        push_rand_frame();
        drive();
        b = 200;
        while (send_q.size() > N/2 && b > 0) begin
            tick();
            b--;
        end
        check("bp_fill", 64'(b == 0), 64'(0));
        repeat (5) tick();
        check("bp_in_ready", 64'(in_ready), 64'(0));
        check("bp_stalled", 64'(send_q.size()), 64'(N/2));
        check("bp_out_valid", 64'(out_valid), 64'(1));
        out_ready = 1'b1;
        c0 = consumed;
        repeat (2*N) tick();
        check("bp_no_gap", 64'(consumed - c0), 64'(2*N));
        run_until_idle("bp", 200);

        // Random output stalls over four frames.
        log0 = out_log.size();
        rnd_ready = 1'b1;
        for (int f = 0; f < 4; f++) push_rand_frame();
        drive();
        run_until_idle("rand", 2000);
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        check("rand_count", 64'(out_log.size() - log0), 64'(4*N));

        // Reset pulse in the middle of draining a frame.
        push_rand_frame();
        drive();
        c0 = consumed;
        b = 100;
        while (consumed - c0 < 3 && b > 0) begin
            tick();
            b--;
        end
        check("rst_mid_reach", 64'(b == 0), 64'(0));
        nrst = 1'b0;
        send_q.delete();
        drive();
        #1;
        check("rst_mid_out_valid", 64'(out_valid), 64'(0));
        check("rst_mid_out_data", 64'({out_re, out_im, out_first, out_last}), 64'(0));
        check("rst_mid_in_ready", 64'(in_ready), 64'(1));
        tick();
        nrst = 1'b1;
        c0 = consumed;
        repeat (16) tick();
        check("rst_silent", 64'(consumed - c0), 64'(0));
        check("rst_silent_valid", 64'(out_valid), 64'(0));
        push_pair(1'b0, 16'h111, 16'h222);
        push_rand_frame();
        drive();
        c0 = consumed;
        run_until_idle("post_rst", 100);
        check("post_rst_count", 64'(consumed - c0), 64'(N));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
